btb_access_sched: RTL and testbench
===================================

BTB_ACCESS_SCHED -- requirements
Module: btb_access_sched

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive lookup grants while an update is pending.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port lk_valid  in  1  fetch lookup request.
REQ-005 SHALL have port lk_pc  in  32  lookup PC.
REQ-006 SHALL have port lk_ready  out  1  lookup accepted this cycle (combinational).
REQ-007 SHALL have port up_valid  in  1  resolved branch/jump update request.
REQ-008 SHALL have port up_pc  in  32  branch instruction PC.
REQ-009 SHALL have port up_tgt  in  32  resolved next PC to store.
REQ-010 SHALL have port up_taken  in  1  branch actually taken.
REQ-011 SHALL have port up_isb  in  1  1 = conditional branch, 0 = jump.
REQ-012 SHALL have port up_ready  out  1  update FIFO can accept (registered).
REQ-013 SHALL have port bt_en  out  1  BTB access this cycle.
REQ-014 SHALL have port bt_we  out  1  the access is a write/update.
REQ-015 SHALL have port bt_pc  out  32  PC presented to the BTB.
REQ-016 SHALL have port bt_tgt  out  32  target for writes; 0 on lookups.
REQ-017 SHALL have port bt_taken  out  1  taken flag for writes; 0 on lookups.
REQ-018 SHALL have port bt_isb  out  1  branch/jump flag for writes; 0 on lookups.
REQ-019 SHALL have port rsp_stale  out  1  lookup PC matched a pending update entry.

Function
REQ-020 SHALL hold a 2-entry update FIFO of {pc, tgt, taken, isb} with a 2-bit occupancy count (0..2).
REQ-021 SHALL drive up_ready = (count < 2), a function of registered state only.
REQ-022 SHALL push an entry when up_valid & up_ready.
REQ-023 SHALL, in one cycle, allow a push and a pop together; count is then unchanged and FIFO order is preserved.
REQ-024 SHALL grant a lookup (lk_ready=1) when lk_valid & count<2 & starve<STARVE_MAX.
REQ-025 SHALL otherwise pop the FIFO head for a write when count>0.
REQ-026 SHALL idle (no grant) when lk_valid=0 and count=0.
REQ-027 SHALL drive lk_ready=0 whenever a write is forced (count=2 or starve=STARVE_MAX), even when lk_valid=1.
REQ-028 SHALL keep a starvation counter (2 bits) that increments on each lookup grant while count>0, clears on any pop, and clears when count=0.
REQ-029 SHALL register all bt_* outputs and rsp_stale one cycle after the grant decision.
REQ-030 SHALL, for a lookup grant, give bt_en=1, bt_we=0, bt_pc=lk_pc, with bt_tgt, bt_taken and bt_isb all 0.
REQ-031 SHALL, for a write grant, give bt_en=1, bt_we=1 and the head entry fields.
REQ-032 SHALL, with no grant, give bt_en=0, bt_we=0 and all data outputs 0.
REQ-033 SHALL set rsp_stale=1 with a lookup grant when lk_pc equals the pc of any valid FIFO entry.
REQ-034 SHALL compare only entries present before this cycle's push.
REQ-035 SHALL drive rsp_stale=0 on writes and idle cycles.
REQ-036 SHALL make an update pushed in cycle N appear as a write no earlier than bt_* of cycle N+2; there is no bypass.
REQ-037 SHALL never drop or reorder updates.
REQ-038 SHALL ignore up_valid while up_ready=0; the requester holds its data.

Reset
REQ-039 SHALL, with rst_n=0 at a rising edge, clear count, starve, FIFO valid state, bt_en, bt_we, bt_pc, bt_tgt, bt_taken, bt_isb and rsp_stale to 0.
REQ-040 SHALL discard in-flight FIFO entries on reset mid-operation.
REQ-041 SHALL drive lk_ready=0 while rst_n=0; up_ready is 1 on the cycle after reset releases.

Verification
REQ-042 SHALL test: lk_valid=1, lk_pc=0x100 with an empty FIFO -> lk_ready=1; next cycle bt_en=1, bt_we=0, bt_pc=0x100, rsp_stale=0.
REQ-043 SHALL test: update pc=0x40, tgt=0x80, taken=1, isb=1 with no lookups -> exactly one write cycle carrying 0x40/0x80/1/1, then count=0.
REQ-044 SHALL test: lk_valid held high plus one pending update -> exactly 3 lookup grants, then 1 forced write with lk_ready=0, then lookups resume.
REQ-045 SHALL test: two updates pushed back-to-back while lookups are active -> up_ready=0 at count=2, next grant is a write, and writes come out in push order.
REQ-046 SHALL test: FIFO holding pc=0x200 and a lookup of 0x200 -> rsp_stale=1 on that lookup; a lookup of 0x204 -> rsp_stale=0.
REQ-047 SHALL test: rst_n=0 asserted with count=2 -> next cycle all outputs 0, no write of the held entries, up_ready=1 after release.

Source files
------------

// File: rtl/btb_access_sched_if.sv
// btb_access_sched_if: fetch lookup, branch update and BTB access bundle
interface btb_access_sched_if;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_ready;
  logic        up_valid;
  logic [31:0] up_pc;
  logic [31:0] up_tgt;
  logic        up_taken;
  logic        up_isb;
  logic        up_ready;
  logic        bt_en;
  logic        bt_we;
  logic [31:0] bt_pc;
  logic [31:0] bt_tgt;
  logic        bt_taken;
  logic        bt_isb;
  logic        rsp_stale;
  modport master (
    output lk_valid, lk_pc, up_valid, up_pc, up_tgt, up_taken, up_isb,
    input  lk_ready, up_ready, bt_en, bt_we, bt_pc, bt_tgt, bt_taken, bt_isb, rsp_stale
  );
  modport slave (
    input  lk_valid, lk_pc, up_valid, up_pc, up_tgt, up_taken, up_isb,
    output lk_ready, up_ready, bt_en, bt_we, bt_pc, bt_tgt, bt_taken, bt_isb, rsp_stale
  );
endinterface

// File: rtl/btb_access_sched.sv
// btb_access_sched: single-port BTB arbiter between fetch lookups and a 2-deep update FIFO
module btb_access_sched #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  btb_access_sched_if.slave  bus
);
  localparam logic [1:0] SMAX = 2'(STARVE_MAX);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        isb;
  } ent_t;
  ent_t        mem_q [2];
  ent_t        mem_d [2];
  ent_t        head;
  logic [1:0]  count_q, count_d, starve_q, starve_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        lk_gnt, wr_gnt, push, hit;
  logic        bt_en_q, bt_en_d, bt_we_q, bt_we_d;
  logic [31:0] bt_pc_q, bt_pc_d, bt_tgt_q, bt_tgt_d;
  logic        bt_taken_q, bt_taken_d, bt_isb_q, bt_isb_d;
  logic        rsp_stale_q, rsp_stale_d;
  always_comb begin
    lk_gnt      = rst_n & bus.lk_valid & (count_q < 2'd2) & (starve_q < SMAX);
    wr_gnt      = rst_n & ~lk_gnt & (count_q != 2'd0);
    push        = bus.up_valid & (count_q < 2'd2);
    head        = mem_q[rd_q];
    // only entries already queued are compared; this cycle's push is not visible yet
    hit         = ((count_q != 2'd0) && (mem_q[rd_q].pc == bus.lk_pc)) ||
                  ((count_q == 2'd2) && (mem_q[~rd_q].pc == bus.lk_pc));
    mem_d       = mem_q;
    mem_d[wr_q] = push ? {bus.up_pc, bus.up_tgt, bus.up_taken, bus.up_isb} : mem_q[wr_q];
    count_d     = count_q + {1'b0, push} - {1'b0, wr_gnt};
    wr_d        = wr_q ^ push;
    rd_d        = rd_q ^ wr_gnt;
    starve_d    = (wr_gnt || count_q == 2'd0) ? 2'd0 : starve_q + {1'b0, lk_gnt};
    bt_en_d     = lk_gnt | wr_gnt;
    bt_we_d     = wr_gnt;
    bt_pc_d     = lk_gnt ? bus.lk_pc : wr_gnt ? head.pc : 32'd0;
    bt_tgt_d    = wr_gnt ? head.tgt : 32'd0;
    bt_taken_d  = wr_gnt & head.taken;
    bt_isb_d    = wr_gnt & head.isb;
    rsp_stale_d = lk_gnt & hit;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      count_q     <= '0;
      starve_q    <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      bt_en_q     <= 1'b0;
      bt_we_q     <= 1'b0;
      bt_pc_q     <= '0;
      bt_tgt_q    <= '0;
      bt_taken_q  <= 1'b0;
      bt_isb_q    <= 1'b0;
      rsp_stale_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      bt_en_q     <= bt_en_d;
      bt_we_q     <= bt_we_d;
      bt_pc_q     <= bt_pc_d;
      bt_tgt_q    <= bt_tgt_d;
      bt_taken_q  <= bt_taken_d;
      bt_isb_q    <= bt_isb_d;
      rsp_stale_q <= rsp_stale_d;
    end
  end
  assign bus.lk_ready  = lk_gnt;
  assign bus.up_ready  = count_q < 2'd2;
  assign bus.bt_en     = bt_en_q;
  assign bus.bt_we     = bt_we_q;
  assign bus.bt_pc     = bt_pc_q;
  assign bus.bt_tgt    = bt_tgt_q;
  assign bus.bt_taken  = bt_taken_q;
  assign bus.bt_isb    = bt_isb_q;
  assign bus.rsp_stale = rsp_stale_q;
endmodule

// File: tb/tb_btb_access_sched.sv
// tb_btb_access_sched: queue-based reference model of the arbiter with directed and random traffic
module tb_btb_access_sched;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        isb;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  btb_access_sched_if bif();
  btb_access_sched #(.STARVE_MAX(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
  ent_t        mq[$];
  logic [68:0] exq[$];
  int          starve = 0;
  int          checks = 0;
  int          failures = 0;
  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // bt word layout: {en, we, pc, tgt, taken, isb, stale}
  task automatic step(input logic lv, input logic [31:0] lpc, input logic uv, input ent_t u,
                      output logic acc, output logic [68:0] bt);
    logic lk, wr, st;
    logic [68:0] e;
    @(negedge clk);
    bif.lk_valid = lv;
    bif.lk_pc    = lpc;
    bif.up_valid = uv;
    {bif.up_pc, bif.up_tgt, bif.up_taken, bif.up_isb} = u;
    #1;
    lk = rst_n && lv && mq.size() < 2 && starve < 3;
    wr = rst_n && !lk && mq.size() > 0;
    st = 1'b0;
    foreach (mq[i]) if (mq[i].pc == lpc) st = 1'b1;
    e = lk ? {2'b10, lpc, 32'h0, 2'b00, st} : wr ? {2'b11, mq[0], 1'b0} : 69'h0;
    chk("lk_ready", 69'(bif.lk_ready), 69'(lk));
    if (rst_n) chk("up_ready", 69'(bif.up_ready), 69'(mq.size() < 2));
    acc = rst_n && uv && mq.size() < 2;
    if (!rst_n) begin
      mq.delete();
      starve = 0;
    end else begin
      starve = (wr || mq.size() == 0) ? 0 : starve + (lk ? 1 : 0);
      if (wr) void'(mq.pop_front());
      if (acc) mq.push_back(u);
    end
    exq.push_back(e);
    @(posedge clk);
    #1;
    bt = {bif.bt_en, bif.bt_we, bif.bt_pc, bif.bt_tgt, bif.bt_taken, bif.bt_isb, bif.rsp_stale};
    chk("bt", bt, exq.pop_front());
  endtask
  task automatic idle(input int n);
    logic a;
    logic [68:0] b;
    repeat (n) step(1'b0, 32'h0, 1'b0, '0, a, b);
  endtask
  initial begin
    logic a;
    logic [68:0] b;
    logic [5:0] seq;
    int n;
    ent_t u1, u2, pu;
    logic pend;
    logic [31:0] pcs [4];
    pcs = '{32'h100, 32'h200, 32'h204, 32'h40};
    bif.lk_valid = 1'b0;
    bif.lk_pc    = '0;
    bif.up_valid = 1'b0;
    bif.up_pc    = '0;
    bif.up_tgt   = '0;
    bif.up_taken = 1'b0;
    bif.up_isb   = 1'b0;
    step(1'b1, 32'h100, 1'b1, '0, a, b);
    step(1'b1, 32'h100, 1'b0, '0, a, b);
    chk("reset_bt", b, 69'h0);
    rst_n = 1'b1;
    step(1'b1, 32'h100, 1'b0, '0, a, b);
    chk("t042", b, {2'b10, 32'h100, 32'h0, 3'b000});
    idle(3);
    step(1'b0, 32'h0, 1'b1, {32'h40, 32'h80, 1'b1, 1'b1}, a, b);
    n = 0;
    repeat (3) begin
      step(1'b0, 32'h0, 1'b0, '0, a, b);
      if (b[67]) begin
        n++;
        chk("t043_wr", b, {2'b11, 32'h40, 32'h80, 3'b110});
      end
    end
    chk("t043_nwr", 69'(n), 69'd1);
    chk("t043_empty", 69'(bif.up_ready), 69'd1);
    idle(2);
    step(1'b1, 32'h300, 1'b1, {32'h300, 32'h310, 1'b1, 1'b0}, a, b);
    seq = 6'd0;
    seq[0] = b[67];
    for (int i = 1; i < 6; i++) begin
      step(1'b1, 32'h300, 1'b0, '0, a, b);
      seq[i] = b[67];
    end
    chk("t044_seq", 69'(seq), 69'(6'b010000));
    idle(3);
    u1 = {32'h500, 32'h510, 1'b1, 1'b1};
    u2 = {32'h600, 32'h610, 1'b0, 1'b0};
    step(1'b1, 32'h100, 1'b1, u1, a, b);
    step(1'b1, 32'h104, 1'b1, u2, a, b);
    chk("t045_full", 69'(bif.up_ready), 69'd0);
    step(1'b1, 32'h108, 1'b0, '0, a, b);
    chk("t045_w1", b, {2'b11, u1, 1'b0});
    step(1'b0, 32'h0, 1'b0, '0, a, b);
    chk("t045_w2", b, {2'b11, u2, 1'b0});
    idle(2);
    step(1'b1, 32'h900, 1'b1, {32'h200, 32'h220, 1'b0, 1'b1}, a, b);
    step(1'b1, 32'h200, 1'b0, '0, a, b);
    chk("t046_hit", 69'(b[0]), 69'd1);
    step(1'b1, 32'h204, 1'b0, '0, a, b);
    chk("t046_miss", 69'(b[0]), 69'd0);
    idle(3);
    step(1'b1, 32'h100, 1'b1, u1, a, b);
    step(1'b1, 32'h104, 1'b1, u2, a, b);
    rst_n = 1'b0;
    step(1'b1, 32'h100, 1'b1, u1, a, b);
    chk("t047_rst", b, 69'h0);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, '0, a, b);
    chk("t047_nowr", b, 69'h0);
    chk("t047_upr", 69'(bif.up_ready), 69'd1);
    idle(2);
    pend = 1'b0;
    pu = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        pu = {pcs[$urandom_range(0, 3)], $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      end
      step(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 3)], pend, pu, a, b);
      if (a) pend = 1'b0;
    end
    idle(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
